demux_bank: RTL

DEMUX_BANK -- requirements
Module: demux_bank

---
 rtl/demux_bank_pkg.sv | 10 +
 rtl/demux_chan.sv | 36 +++
 rtl/demux_bank.sv | 94 +++++++++
 3 files changed

// File: rtl/demux_bank_pkg.sv
// rtl/demux_bank_pkg.sv - shared constants for the demux channel bank
package demux_bank_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NCH   = 8;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_SEQ  = 1'b1;

endpackage

// File: rtl/demux_chan.sv
// rtl/demux_chan.sv - one channel: data register plus loaded flag
module demux_chan
    import demux_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    // Data register: loads on write, holds through a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

    // Loaded flag: a same-cycle write wins over clear (clear first, then write).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_bank.sv
// rtl/demux_bank.sv - write demultiplexer into a bank of NCH channel registers
module demux_bank
    import demux_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 bcast,
    input  logic                 clr,
    output logic [NCH*WIDTH-1:0] dout,
    output logic [NCH-1:0]       dout_valid,
    output logic                 full,
    output logic [SELW-1:0]      wr_ptr,
    output logic                 err,
    output logic                 ovf
);

    // One extra bit so NCH itself is representable when NCH is a power of two.
    localparam logic [SELW:0]   NCH_W    = (SELW + 1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);

    logic           in_range;
    logic [NCH-1:0] load;
    logic           err_next;
    logic           ovf_next;
    logic           seq_write;

    assign in_range  = {1'b0, sel} < NCH_W;
    assign seq_write = din_valid && !bcast && (mode == MODE_SEQ);
    assign err_next  = din_valid && !bcast && (mode == MODE_ADDR) && !in_range;
    // Overwrite check uses the pre-clear flags; broadcast reduces to "any valid".
    assign ovf_next  = |(load & dout_valid);
    assign full      = &dout_valid;

    // Per-channel load strobes: broadcast, sequential pointer, or in-range select.
    always_comb begin
        load = '0;
        for (int k = 0; k < NCH; k++) begin
            if (din_valid) begin
                if (bcast) begin
                    load[k] = 1'b1;
                end else if (mode == MODE_SEQ) begin
                    load[k] = (wr_ptr == SELW'(k));
                end else begin
                    load[k] = in_range && (sel == SELW'(k));
                end
            end
        end
    end

    // Sequential pointer: clear forces 0 even when the same cycle writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
        end else if (seq_write) begin
            wr_ptr <= (wr_ptr == LAST_CH) ? '0 : wr_ptr + SELW'(1);
        end
    end

    // Single-cycle status pulses for the write just accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
            ovf <= 1'b0;
        end else begin
            err <= err_next;
            ovf <= ovf_next;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        demux_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .load (load[k]),
            .clr  (clr),
            .d    (din),
            .q    (dout[k*WIDTH +: WIDTH]),
            .valid(dout_valid[k])
        );
    end

endmodule
